cubic_interp_engine: RTL and testbench



---
 rtl/cubic_interp_engine_if.sv | 40 ++++
 rtl/cubic_interp_engine.sv | 183 ++++++++++++++++++
 tb/tb_cubic_interp_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cubic_interp_engine_if.sv
// Request/response bus of cubic_interp_engine.
// Parameters must match the engine instance they connect to.
//   master: requester side (drives request and out_ready)
//   slave : engine side (drives in_ready, result, busy)
// Signals:
//   in_valid/in_ready   request handshake
//   p0..p3              samples at offsets -1,0,+1,+2; channel c at [c*DATA_W +: DATA_W]
//   x_num/x_den         rational position t = x_num/x_den
//   out_valid/out_ready result handshake
//   out_data/out_err    interpolated samples / illegal-position flag
//   busy                engine not idle
interface cubic_interp_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH     = 1,
  parameter int unsigned POS_W  = 12
);
  logic                   in_valid;
  logic                   in_ready;
  logic [CH*DATA_W-1:0]   p0;
  logic [CH*DATA_W-1:0]   p1;
  logic [CH*DATA_W-1:0]   p2;
  logic [CH*DATA_W-1:0]   p3;
  logic [POS_W-1:0]       x_num;
  logic [POS_W-1:0]       x_den;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH*DATA_W-1:0]   out_data;
  logic                   out_err;
  logic                   busy;

  modport master (
    output in_valid, p0, p1, p2, p3, x_num, x_den, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy
  );

  modport slave (
    input  in_valid, p0, p1, p2, p3, x_num, x_den, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/cubic_interp_engine.sv
// Catmull-Rom (a=-0.5) cubic interpolation engine, sequential MAC + restoring divider.
// Channels are evaluated one after another, channel 0 first.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset (aborts any transaction)
//   bus  cubic_interp_engine_if.slave: request/result handshakes, samples, position
// Optional feature: define CUBIC_EXACT_SHORTCUT_EN to answer legal t=0 / t=1 requests
// directly from p1 / p2 one cycle after accept (values identical, only latency differs).
module cubic_interp_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH     = 1,
  parameter int unsigned POS_W  = 12
) (
  input  logic                   CLK,
  input  logic                   RST,
  cubic_interp_engine_if.slave   bus
);

  localparam int unsigned ACC_W = DATA_W + 3*POS_W + 6;
  localparam int unsigned PW2   = 2*POS_W;
  localparam int unsigned PW3   = 3*POS_W;
  localparam int unsigned CHW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned DCW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CHW-1:0] CH_LAST  = CHW'(CH - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DATA_W - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_CHK, S_DIV, S_OUT
  } state_t;

  state_t state, state_next;

  logic [CH*DATA_W-1:0]     p0_r, p1_r, p2_r, p3_r, out_data_r;
  logic                     out_err_r;
  logic [POS_W-1:0]         xn_r, xd_r;
  logic [PW2-1:0]           a2_r, x2_r;
  logic [PW3-1:0]           a3_r, x3_r;
  logic signed [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]         rem, dsh;
  logic [DATA_W-1:0]        quo, sat_val;
  logic                     sat;
  logic [CHW-1:0]           ch_idx;
  logic [DCW-1:0]           div_cnt;

  logic accept, illegal, shortcut;

  assign accept  = bus.in_valid && (state == S_IDLE);
  assign illegal = (bus.x_den == '0) || (bus.x_num > bus.x_den);
`ifdef CUBIC_EXACT_SHORTCUT_EN
  assign shortcut = !illegal && ((bus.x_num == '0) || (bus.x_num == bus.x_den));
`else
  assign shortcut = 1'b0;
`endif

  // Current channel samples and coefficients, signed at accumulator width
  logic [DATA_W-1:0]       s0, s1, s2, s3;
  logic signed [ACC_W-1:0] e0, e1, e2, e3, ca, cb, cc;

  assign s0 = p0_r[ch_idx*DATA_W +: DATA_W];
  assign s1 = p1_r[ch_idx*DATA_W +: DATA_W];
  assign s2 = p2_r[ch_idx*DATA_W +: DATA_W];
  assign s3 = p3_r[ch_idx*DATA_W +: DATA_W];
  assign e0 = signed'(ACC_W'(s0));
  assign e1 = signed'(ACC_W'(s1));
  assign e2 = signed'(ACC_W'(s2));
  assign e3 = signed'(ACC_W'(s3));
  assign ca = e3 - e0 + ((e1 - e2) <<< 1) + (e1 - e2);
  assign cb = (e0 <<< 1) - (e1 <<< 2) - e1 + (e2 <<< 2) - e3;
  assign cc = e2 - e0;

  // One MAC term per cycle: signed coefficient times unsigned position product
  logic signed [ACC_W-1:0] coef, term;
  logic [PW3-1:0]          mag;

  always_comb begin
    coef = '0;
    mag  = '0;
    case (state)
      S_MAC0: begin coef = e1 <<< 1; mag = a3_r;                        end
      S_MAC1: begin coef = cc;       mag = PW3'(xn_r) * PW3'(a2_r);     end
      S_MAC2: begin coef = cb;       mag = PW3'(x2_r) * PW3'(xd_r);     end
      S_MAC3: begin coef = ca;       mag = x3_r;                        end
      default: ;
    endcase
  end

  assign term = coef * signed'(ACC_W'(mag));

  logic signed [ACC_W-1:0] dvd;
  logic [ACC_W-1:0]        thr;
  logic                    d_ge;
  logic [DATA_W-1:0]       q_next;

  assign dvd    = acc + signed'(ACC_W'(a3_r));
  assign thr    = ACC_W'(a3_r) << (DATA_W + 1);
  assign d_ge   = rem >= dsh;
  assign q_next = DATA_W'({quo, d_ge});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (illegal || shortcut) ? S_OUT : S_PREP;
      S_PREP: state_next = S_MAC0;
      S_MAC0: state_next = S_MAC1;
      S_MAC1: state_next = S_MAC2;
      S_MAC2: state_next = S_MAC3;
      S_MAC3: state_next = S_CHK;
      S_CHK:  state_next = S_DIV;
      S_DIV:  if (div_cnt == DIV_LAST) state_next = (ch_idx == CH_LAST) ? S_OUT : S_MAC0;
      S_OUT:  if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p0_r <= '0; p1_r <= '0; p2_r <= '0; p3_r <= '0;
      xn_r <= '0; xd_r <= '0;
      a2_r <= '0; a3_r <= '0; x2_r <= '0; x3_r <= '0;
      acc <= '0; rem <= '0; dsh <= '0; quo <= '0;
      sat <= 1'b0; sat_val <= '0;
      ch_idx <= '0; div_cnt <= '0;
      out_data_r <= '0; out_err_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          p0_r <= bus.p0; p1_r <= bus.p1; p2_r <= bus.p2; p3_r <= bus.p3;
          xn_r <= bus.x_num; xd_r <= bus.x_den;
          ch_idx <= '0;
          out_err_r <= illegal;
          if (illegal)       out_data_r <= bus.p1;
          else if (shortcut) out_data_r <= (bus.x_num == '0) ? bus.p1 : bus.p2;
        end
        S_PREP: begin
          a2_r <= PW2'(xd_r) * PW2'(xd_r);
          a3_r <= PW3'(xd_r) * PW3'(xd_r) * PW3'(xd_r);
          x2_r <= PW2'(xn_r) * PW2'(xn_r);
          x3_r <= PW3'(xn_r) * PW3'(xn_r) * PW3'(xn_r);
        end
        S_MAC0: acc <= term;
        S_MAC1, S_MAC2, S_MAC3: acc <= acc + term;
        S_CHK: begin
          // Divisor 2*A3 pre-aligned to the MSB quotient bit
          div_cnt <= '0;
          quo     <= '0;
          dsh     <= ACC_W'(a3_r) << DATA_W;
          rem     <= unsigned'(dvd);
          if (acc[ACC_W-1]) begin
            sat <= 1'b1; sat_val <= '0;
          end else if (unsigned'(dvd) >= thr) begin
            sat <= 1'b1; sat_val <= '1;
          end else begin
            sat <= 1'b0;
          end
        end
        S_DIV: begin
          // Saturated channels still run the full divider so latency stays fixed
          if (d_ge) rem <= rem - dsh;
          dsh     <= dsh >> 1;
          quo     <= q_next;
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DIV_LAST) begin
            out_data_r[ch_idx*DATA_W +: DATA_W] <= sat ? sat_val : q_next;
            ch_idx <= ch_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_data  = out_data_r;
  assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_cubic_interp_engine.sv
module tb_cubic_interp_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cubic_interp_engine_if #(.DATA_W(8), .CH(1), .POS_W(12)) bus1 ();
  cubic_interp_engine_if #(.DATA_W(8), .CH(3), .POS_W(12)) bus3 ();

  cubic_interp_engine #(.DATA_W(8), .CH(1), .POS_W(12)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));
  cubic_interp_engine #(.DATA_W(8), .CH(3), .POS_W(12)) dut3 (.CLK(clk), .RST(rst), .bus(bus3));

`ifdef CUBIC_EXACT_SHORTCUT_EN
  localparam int LAT_EXACT = 1;
`else
  localparam int LAT_EXACT = 15;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Round-half-up of the Catmull-Rom polynomial, clamped to [0,255]
  function automatic longint fdiv(input longint n, input longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic int ref_val(input int p0, p1, p2, p3, xn, xd);
    longint t1, t2, t3, s, r;
    if (xd == 0 || xn > xd) return p1;
    t1 = longint'(xn) * xd * xd;
    t2 = longint'(xn) * xn * xd;
    t3 = longint'(xn) * xn * xn;
    // 2*f(t)*xd^3
    s = 2 * longint'(p1) * xd * xd * xd
      + longint'(p2 - p0) * t1
      + longint'(2*p0 - 5*p1 + 4*p2 - p3) * t2
      + longint'(3*p1 - p0 - 3*p2 + p3) * t3;
    r = fdiv(2 * s + 2 * longint'(xd) * xd * xd, 4 * longint'(xd) * xd * xd);
    if (r < 0)   r = 0;
    if (r > 255) r = 255;
    return int'(r);
  endfunction

  function automatic logic out_v(input bit big);
    return big ? bus3.out_valid : bus1.out_valid;
  endfunction

  // One transaction; result held for 'hold' cycles with out_ready=0 before release
  task automatic run(input bit big, input logic [23:0] q0, q1, q2, q3,
                     input int xn, xd, input int hold,
                     output logic [23:0] d, output logic e, output int lat,
                     output bit stable);
    @(negedge clk);
    if (big) begin
      bus3.in_valid = 1'b1; bus3.p0 = q0; bus3.p1 = q1; bus3.p2 = q2; bus3.p3 = q3;
      bus3.x_num = 12'(xn); bus3.x_den = 12'(xd);
    end else begin
      bus1.in_valid = 1'b1; bus1.p0 = q0[7:0]; bus1.p1 = q1[7:0];
      bus1.p2 = q2[7:0]; bus1.p3 = q3[7:0];
      bus1.x_num = 12'(xn); bus1.x_den = 12'(xd);
    end
    @(posedge clk);
    #1;
    if (big) begin
      bus3.in_valid = 1'b0; bus3.p1 = 24'($urandom); bus3.p2 = 24'($urandom);
      bus3.x_num = 12'($urandom);
    end else begin
      bus1.in_valid = 1'b0; bus1.p1 = 8'($urandom); bus1.p2 = 8'($urandom);
      bus1.x_num = 12'($urandom);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_v(big) && lat < 200);
    if (!out_v(big)) lat = -1;
    d = big ? bus3.out_data : {16'b0, bus1.out_data};
    e = big ? bus3.out_err : bus1.out_err;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (big) begin
        if (!bus3.out_valid || bus3.out_data != d || bus3.out_err != e || bus3.in_ready) stable = 1'b0;
      end else begin
        if (!bus1.out_valid || bus1.out_data != d[7:0] || bus1.out_err != e || bus1.in_ready) stable = 1'b0;
      end
    end
    if (big) bus3.out_ready = 1'b1; else bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus3.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
  endtask

  typedef struct {
    string name;
    int p0, p1, p2, p3, xn, xd, exp_d, exp_e, exp_lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] d;
    logic e;
    int lat;
    bit st;
    int rp0, rp1, rp2, rp3, rxn, rxd, sel, elat;
    logic [23:0] q0, q1, q2, q3, exp24;
    int seen;

    tbl[0] = '{"mid_linear", 10, 20, 30, 40, 1, 2, 25, 0, 15};
    tbl[1] = '{"clamp_hi",    0, 255, 255, 0, 1, 2, 255, 0, 15};
    tbl[2] = '{"clamp_lo",  255, 0, 0, 255, 1, 2, 0, 0, 15};
    tbl[3] = '{"round",       0, 0, 1, 0, 1, 2, 1, 0, 15};
    tbl[4] = '{"den_zero",    1, 77, 3, 4, 1, 0, 77, 1, 1};
    tbl[5] = '{"num_gt_den",  1, 77, 3, 4, 5, 4, 77, 1, 1};
    tbl[6] = '{"t_zero",     12, 34, 56, 78, 0, 7, 34, 0, LAT_EXACT};
    tbl[7] = '{"t_one",      12, 34, 56, 78, 7, 7, 56, 0, LAT_EXACT};

    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.p0 = '0; bus1.p1 = '0; bus1.p2 = '0; bus1.p3 = '0; bus1.x_num = '0; bus1.x_den = '0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0;
    bus3.p0 = '0; bus3.p1 = '0; bus3.p2 = '0; bus3.p3 = '0; bus3.x_num = '0; bus3.x_den = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus1.out_valid, 0);
    chk("rst_out_data",  bus1.out_data, 0);
    chk("rst_out_err",   bus1.out_err, 0);
    chk("rst_busy",      bus1.busy, 0);
    chk("rst_in_ready",  bus1.in_ready, 1);
    chk("rst3_out_data", bus3.out_data, 0);
    chk("rst3_in_ready", bus3.in_ready, 1);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run(1'b0, 24'(tbl[i].p0), 24'(tbl[i].p1), 24'(tbl[i].p2), 24'(tbl[i].p3),
          tbl[i].xn, tbl[i].xd, 0, d, e, lat, st);
      chk({tbl[i].name, "_data"}, d, tbl[i].exp_d);
      chk({tbl[i].name, "_err"},  e, tbl[i].exp_e);
      chk({tbl[i].name, "_lat"},  lat, tbl[i].exp_lat);
    end

    for (int i = 0; i < 40; i++) begin
      rp0 = $urandom_range(0, 255); rp1 = $urandom_range(0, 255);
      rp2 = $urandom_range(0, 255); rp3 = $urandom_range(0, 255);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        rxd = $urandom_range(0, 4094); rxn = $urandom_range(rxd + 1, 4095);
      end else if (sel == 1) begin
        rxd = $urandom_range(1, 4095); rxn = 0;
      end else if (sel == 2) begin
        rxd = $urandom_range(1, 4095); rxn = rxd;
      end else begin
        rxd = $urandom_range(1, 4095); rxn = $urandom_range(0, rxd);
      end
      if (rxd == 0 || rxn > rxd)        elat = 1;
      else if (rxn == 0 || rxn == rxd)  elat = LAT_EXACT;
      else                              elat = 15;
      run(1'b0, 24'(rp0), 24'(rp1), 24'(rp2), 24'(rp3), rxn, rxd,
          $urandom_range(0, 2), d, e, lat, st);
      chk($sformatf("rnd%0d_data", i), d, ref_val(rp0, rp1, rp2, rp3, rxn, rxd));
      chk($sformatf("rnd%0d_err", i),  e, (rxd == 0 || rxn > rxd) ? 1 : 0);
      chk($sformatf("rnd%0d_lat", i),  lat, elat);
    end

    // Three channels with 10 cycles of backpressure
    run(1'b1, {8'd0, 8'd0, 8'd10}, {8'd255, 8'd0, 8'd20}, {8'd255, 8'd1, 8'd30},
        {8'd0, 8'd0, 8'd40}, 1, 2, 10, d, e, lat, st);
    chk("ch3_data", d, {8'd255, 8'd1, 8'd25});
    chk("ch3_err", e, 0);
    chk("ch3_lat", lat, 41);
    chk("ch3_hold_stable", st, 1);
    chk("ch3_in_ready_after", bus3.in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      q0 = 24'($urandom); q1 = 24'($urandom); q2 = 24'($urandom); q3 = 24'($urandom);
      rxd = $urandom_range(2, 4095); rxn = $urandom_range(1, rxd - 1);
      for (int c = 0; c < 3; c++)
        exp24[c*8 +: 8] = 8'(ref_val(int'(q0[c*8 +: 8]), int'(q1[c*8 +: 8]),
                                     int'(q2[c*8 +: 8]), int'(q3[c*8 +: 8]), rxn, rxd));
      run(1'b1, q0, q1, q2, q3, rxn, rxd, 1, d, e, lat, st);
      chk($sformatf("ch3rnd%0d_data", i), d, exp24);
      chk($sformatf("ch3rnd%0d_lat", i), lat, 41);
    end

    // Reset while dut1 is dividing
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.p0 = 8'd10; bus1.p1 = 8'd20; bus1.p2 = 8'd30; bus1.p3 = 8'd40;
    bus1.x_num = 12'd1; bus1.x_den = 12'd2;
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", bus1.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", bus1.in_ready, 1);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus1.out_valid) seen++;
    end
    chk("post_rst_no_valid", seen, 0);
    chk("post_rst_in_ready", bus1.in_ready, 1);
    run(1'b0, 24'd5, 24'd99, 24'd7, 24'd3, 0, 3, 0, d, e, lat, st);
    chk("after_rst_data", d, 99);
    chk("after_rst_err", e, 0);
    chk("after_rst_lat", lat, LAT_EXACT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
